// File: rtl/change_payout.sv
// Coin-out controller: pays a change amount one coin at a time to the hopper,
// tracks per-denomination inventory and reports any unpaid remainder.
module change_payout #(
  parameter int CNT_W       = 8,
  parameter int INIT_CNT_2  = 50,
  parameter int INIT_CNT_5  = 50,
  parameter int INIT_CNT_10 = 50,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             change_valid,
  input  logic [7:0]       change_amount,
  output logic             change_ready,
  output logic [1:0]       coin_out,
  output logic             coin_valid,
  input  logic             coin_ack,
  input  logic             refill,
  input  logic [1:0]       refill_coin,
  input  logic [CNT_W-1:0] refill_count,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt5,
  output logic [CNT_W-1:0] cnt10,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [7:0]       shortfall
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_ISSUE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [7:0]       rem_q, rem_d;
  logic [1:0]       coin_q, coin_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic             error_q, error_d;
  logic [7:0]       short_q, short_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d, cnt5_q, cnt5_d, cnt10_q, cnt10_d;
  logic [1:0]       pick;
  logic             ack_dec;

  // A coin is usable only if it leaves a remainder that can still be paid (never 1 or 3).
  function automatic logic fits(input logic [7:0] rem, input logic [7:0] val,
                                input logic [CNT_W-1:0] cnt);
    logic [7:0] left;
    left = rem - val;
    return (rem >= val) && (cnt != '0) && (left != 8'd1) && (left != 8'd3);
  endfunction

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    case (code)
      2'b01:   return 8'd2;
      2'b10:   return 8'd5;
      2'b11:   return 8'd10;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] add,
                                                input logic dec);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {1'b0, add} - {{CNT_W{1'b0}}, dec};
    if (sum[CNT_W]) return '1;
    return sum[CNT_W-1:0];
  endfunction

  always_comb begin
    pick = 2'b00;
    if (fits(rem_q, 8'd10, cnt10_q))     pick = 2'b11;
    else if (fits(rem_q, 8'd5, cnt5_q))  pick = 2'b10;
    else if (fits(rem_q, 8'd2, cnt2_q))  pick = 2'b01;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    coin_d  = coin_q;
    wait_d  = wait_q;
    error_d = error_q;
    short_d = short_q;
    ack_dec = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (change_valid) begin
          rem_d   = change_amount;
          error_d = 1'b0;
          short_d = 8'd0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == 8'd0) begin
          error_d = 1'b0;
          short_d = 8'd0;
          state_d = S_DONE;
        end else if (pick != 2'b00) begin
          coin_d  = pick;
          wait_d  = '0;
          state_d = S_ISSUE;
        end else begin
          error_d = 1'b1;
          short_d = rem_q;
          state_d = S_DONE;
        end
      end
      S_ISSUE: begin
        if (coin_ack) begin
          rem_d   = rem_q - coin_value(coin_q);
          ack_dec = 1'b1;
          state_d = S_SELECT;
        end else if (wait_q == TO_W'(ACK_TIMEOUT - 1)) begin
          // Hopper stalled: abandon the request, inventory untouched.
          error_d = 1'b1;
          short_d = rem_q;
          state_d = S_DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cnt2_d  = next_cnt(cnt2_q,  (refill && refill_coin == 2'b01) ? refill_count : '0,
                       ack_dec && coin_q == 2'b01);
    cnt5_d  = next_cnt(cnt5_q,  (refill && refill_coin == 2'b10) ? refill_count : '0,
                       ack_dec && coin_q == 2'b10);
    cnt10_d = next_cnt(cnt10_q, (refill && refill_coin == 2'b11) ? refill_count : '0,
                       ack_dec && coin_q == 2'b11);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= 8'd0;
      coin_q  <= 2'b00;
      wait_q  <= '0;
      error_q <= 1'b0;
      short_q <= 8'd0;
      cnt2_q  <= CNT_W'(INIT_CNT_2);
      cnt5_q  <= CNT_W'(INIT_CNT_5);
      cnt10_q <= CNT_W'(INIT_CNT_10);
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      coin_q  <= coin_d;
      wait_q  <= wait_d;
      error_q <= error_d;
      short_q <= short_d;
      cnt2_q  <= cnt2_d;
      cnt5_q  <= cnt5_d;
      cnt10_q <= cnt10_d;
    end
  end

  assign change_ready = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign coin_valid   = (state_q == S_ISSUE);
  assign coin_out     = coin_valid ? coin_q : 2'b00;
  assign cnt2         = cnt2_q;
  assign cnt5         = cnt5_q;
  assign cnt10        = cnt10_q;
  assign error        = error_q;
  assign shortfall    = short_q;

endmodule

// File: tb/tb_change_payout.sv
// Self-checking bench for change_payout: a per-cycle behavioural model of the
// payout rules plus directed scenarios with hand-computed expectations.
module tb_change_payout;

  localparam int CNT_W       = 8;
  localparam int INIT        = 50;
  localparam int ACK_TIMEOUT = 255;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             change_valid;
  logic [7:0]       change_amount;
  logic             change_ready;
  logic [1:0]       coin_out;
  logic             coin_valid;
  logic             coin_ack;
  logic             refill;
  logic [1:0]       refill_coin;
  logic [CNT_W-1:0] refill_count;
  logic [CNT_W-1:0] cnt2, cnt5, cnt10;
  logic             busy, done, error;
  logic [7:0]       shortfall;

  always #5 clk = ~clk;

  change_payout #(
    .CNT_W(CNT_W), .INIT_CNT_2(INIT), .INIT_CNT_5(INIT), .INIT_CNT_10(INIT),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .change_valid(change_valid), .change_amount(change_amount), .change_ready(change_ready),
    .coin_out(coin_out), .coin_valid(coin_valid), .coin_ack(coin_ack),
    .refill(refill), .refill_coin(refill_coin), .refill_count(refill_count),
    .cnt2(cnt2), .cnt5(cnt5), .cnt10(cnt10),
    .busy(busy), .done(done), .error(error), .shortfall(shortfall)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Model: denomination index 0/1/2 = 2/5/10 rupees, coin code = index+1.
  typedef enum {M_IDLE, M_PICK, M_EJECT, M_END} mphase_t;
  mphase_t m_phase;
  int      m_cnt[3];
  int      m_rem, m_idx, m_wait, m_short, m_dec, m_sum;
  bit      m_err;
  int      coin_log[$];
  int      valid_cycles;

  function automatic int coin_val(input int k);
    return (k == 0) ? 2 : (k == 1) ? 5 : 10;
  endfunction

  // Largest coin in stock that fits and leaves a payable remainder (not 1 or 3).
  function automatic int pick_coin(input int rem);
    for (int k = 2; k >= 0; k--)
      if (coin_val(k) <= rem && m_cnt[k] > 0 && (rem - coin_val(k)) != 1 && (rem - coin_val(k)) != 3)
        return k;
    return -1;
  endfunction

  function automatic int log_at(input int i);
    if (i < coin_log.size()) return coin_log[i];
    return -1;
  endfunction

  // Outputs are sampled mid-cycle, then the model steps using the inputs the next edge will see.
  always @(negedge clk) begin
    if (!reset_n) begin
      checkOutput("rst_ready", int'(change_ready), 1);
      checkOutput("rst_valid", int'(coin_valid), 0);
      checkOutput("rst_coin_out", int'(coin_out), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_done", int'(done), 0);
      checkOutput("rst_error", int'(error), 0);
      checkOutput("rst_shortfall", int'(shortfall), 0);
      m_phase = M_IDLE;
      m_err   = 1'b0;
      m_short = 0;
      m_rem   = 0;
      for (int k = 0; k < 3; k++) m_cnt[k] = INIT;
    end else begin
      checkOutput("ready", int'(change_ready), int'(m_phase == M_IDLE));
      checkOutput("busy", int'(busy), int'(m_phase != M_IDLE));
      checkOutput("done", int'(done), int'(m_phase == M_END));
      checkOutput("coin_valid", int'(coin_valid), int'(m_phase == M_EJECT));
      checkOutput("coin_out", int'(coin_out), (m_phase == M_EJECT) ? m_idx + 1 : 0);
      checkOutput("error", int'(error), int'(m_err));
      checkOutput("shortfall", int'(shortfall), m_short);
      checkOutput("cnt2", int'(cnt2), m_cnt[0]);
      checkOutput("cnt5", int'(cnt5), m_cnt[1]);
      checkOutput("cnt10", int'(cnt10), m_cnt[2]);
      if (coin_valid) valid_cycles++;

      m_dec = -1;
      case (m_phase)
        M_IDLE: if (change_valid) begin
          m_rem = int'(change_amount); m_err = 1'b0; m_short = 0; m_phase = M_PICK;
        end
        M_PICK: begin
          m_idx = pick_coin(m_rem);
          if (m_idx < 0) begin
            m_err = (m_rem != 0); m_short = m_rem; m_phase = M_END;
          end else begin
            m_wait = 1; m_phase = M_EJECT;
          end
        end
        M_EJECT: begin
          if (coin_ack) begin
            coin_log.push_back(int'(coin_out));
            m_dec = m_idx; m_rem -= coin_val(m_idx); m_phase = M_PICK;
          end else if (m_wait == ACK_TIMEOUT) begin
            m_err = 1'b1; m_short = m_rem; m_phase = M_END;
          end else m_wait++;
        end
        default: m_phase = M_IDLE;
      endcase

      for (int k = 0; k < 3; k++) begin
        m_sum = m_cnt[k] - ((m_dec == k) ? 1 : 0);
        if (refill && int'(refill_coin) == k + 1) m_sum += int'(refill_count);
        m_cnt[k] = (m_sum > CNT_MAX) ? CNT_MAX : m_sum;
      end
    end
  end

  // Hopper: acks after ack_delay extra cycles of coin_valid when enabled.
  bit ack_en;
  int ack_delay;
  bit force_ack;
  initial begin
    int seen;
    seen = 0;
    coin_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ack_en && coin_valid) begin
        seen++;
        coin_ack = (seen > ack_delay);
      end else begin
        seen = 0;
        coin_ack = force_ack;
      end
    end
  end

  // Issues one request and waits (bounded) for done; lat counts cycles after the accept edge.
  task automatic applyStimulus(input int amount, output int lat);
    int guard;
    coin_log.delete();
    valid_cycles = 0;
    guard = 0;
    while (!change_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    checkOutput("ready_wait", int'(change_ready), 1);
    change_amount = 8'(amount);
    change_valid  = 1'b1;
    @(posedge clk); #1;
    change_valid = 1'b0;
    lat = 1;
    while (!done && lat < 3000) begin @(posedge clk); #1; lat++; end
    checkOutput("done_seen", int'(done), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, guard;
    reset_n = 1'b1; change_valid = 1'b0; change_amount = 8'd0;
    refill = 1'b0; refill_coin = 2'b00; refill_count = '0;
    ack_en = 1'b1; ack_delay = 0; force_ack = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cnt2", int'(cnt2), 50);
    checkOutput("reset_cnt10", int'(cnt10), 50);
    reset_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(17, lat);
    checkOutput("a17_ncoins", coin_log.size(), 3);
    checkOutput("a17_coin0", log_at(0), 3);
    checkOutput("a17_coin1", log_at(1), 2);
    checkOutput("a17_coin2", log_at(2), 1);
    checkOutput("a17_error", int'(error), 0);
    checkOutput("a17_cnt2", int'(cnt2), 49);
    checkOutput("a17_cnt5", int'(cnt5), 49);
    checkOutput("a17_cnt10", int'(cnt10), 49);

    applyStimulus(8, lat);
    checkOutput("a8_ncoins", coin_log.size(), 4);
    for (int i = 0; i < 4; i++) checkOutput("a8_coin", log_at(i), 1);
    checkOutput("a8_cnt2", int'(cnt2), 45);

    applyStimulus(6, lat);
    checkOutput("a6_ncoins", coin_log.size(), 3);
    checkOutput("a6_shortfall", int'(shortfall), 0);
    checkOutput("a6_cnt2", int'(cnt2), 42);

    applyStimulus(3, lat);
    checkOutput("a3_latency", lat, 2);
    checkOutput("a3_valid_cycles", valid_cycles, 0);
    checkOutput("a3_error", int'(error), 1);
    checkOutput("a3_shortfall", int'(shortfall), 3);

    applyStimulus(0, lat);
    checkOutput("a0_latency", lat, 2);
    checkOutput("a0_error", int'(error), 0);

    // Stray acks while idle must not touch inventory.
    ack_en = 1'b0; force_ack = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    force_ack = 1'b0; ack_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("stray_cnt2", int'(cnt2), 42);
    checkOutput("stray_cnt10", int'(cnt10), 49);

    ack_en = 1'b0;
    applyStimulus(17, lat);
    ack_en = 1'b1;
    checkOutput("tmo_valid_cycles", valid_cycles, ACK_TIMEOUT);
    checkOutput("tmo_latency", lat, ACK_TIMEOUT + 2);
    checkOutput("tmo_error", int'(error), 1);
    checkOutput("tmo_shortfall", int'(shortfall), 17);
    checkOutput("tmo_cnt10", int'(cnt10), 49);

    // Reset during the second coin of a 17-rupee payout.
    ack_delay = 2;
    coin_log.delete();
    change_amount = 8'd17; change_valid = 1'b1;
    @(posedge clk); #1;
    change_valid = 1'b0;
    guard = 0;
    while (!(coin_log.size() == 1 && coin_valid) && guard < 50) begin @(posedge clk); #1; guard++; end
    checkOutput("mid_second_issue", int'(coin_valid), 1);
    checkOutput("mid_second_code", int'(coin_out), 2);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", int'(coin_valid), 0);
    checkOutput("mid_rst_ready", int'(change_ready), 1);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_cnt10", int'(cnt10), 50);
    checkOutput("mid_rst_cnt2", int'(cnt2), 50);
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    ack_delay = 0;
    applyStimulus(17, lat);
    checkOutput("post_rst_ncoins", coin_log.size(), 3);
    checkOutput("post_rst_cnt10", int'(cnt10), 49);

    // Refill of tens held through a payout of three tens.
    refill_coin = 2'b11; refill_count = 8'd1; refill = 1'b1;
    applyStimulus(30, lat);
    refill = 1'b0;
    checkOutput("a30_coin2", log_at(2), 3);
    checkOutput("refill_cnt10", int'(cnt10), 55);

    refill_coin = 2'b01; refill_count = 8'd255; refill = 1'b1;
    @(posedge clk); #1;
    refill = 1'b0;
    checkOutput("sat_cnt2", int'(cnt2), 255);

    refill_coin = 2'b01; refill_count = 8'd2; refill = 1'b1;
    applyStimulus(4, lat);
    refill = 1'b0;
    checkOutput("sat_ack_ncoins", coin_log.size(), 2);
    checkOutput("sat_ack_cnt2", int'(cnt2), 255);

    refill_coin = 2'b00; refill_count = 8'd5; refill = 1'b1;
    @(posedge clk); #1;
    refill = 1'b0;
    checkOutput("code0_cnt5", int'(cnt5), 49);

    // Drain tens and fives, then leave a single 2-rupee coin.
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(250, lat);
    checkOutput("drain_cnt10_a", int'(cnt10), 25);
    applyStimulus(250, lat);
    checkOutput("drain_cnt10_b", int'(cnt10), 0);
    applyStimulus(255, lat);
    checkOutput("drain5_shortfall", int'(shortfall), 5);
    checkOutput("drain5_cnt5", int'(cnt5), 0);
    applyStimulus(98, lat);
    checkOutput("drain2_error", int'(error), 0);
    checkOutput("drain2_cnt2", int'(cnt2), 1);
    applyStimulus(20, lat);
    checkOutput("a20_ncoins", coin_log.size(), 1);
    checkOutput("a20_coin0", log_at(0), 1);
    checkOutput("a20_error", int'(error), 1);
    checkOutput("a20_shortfall", int'(shortfall), 18);
    checkOutput("a20_cnt2", int'(cnt2), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
